// File: rtl/id_pkg.sv
// Shared decode encodings and ID/EX control bundle for the decode stage.
package id_pkg;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;
  localparam logic [1:0] OP_ILL = 2'b11;

  localparam logic [1:0] IMM_U12 = 2'b00;
  localparam logic [1:0] IMM_U8  = 2'b01;
  localparam logic [1:0] IMM_S12 = 2'b10;

  localparam logic [2:0] ALU_ADD = 3'b000;

  localparam logic [15:0] STALL_MAX = 16'hFFFF;

  typedef enum logic {ST_RUN = 1'b0, ST_BUBBLE = 1'b1} state_e;

  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       alu_src;
    logic       branch;
    logic [2:0] alu_op;
    logic [3:0] rd;
  } ctrl_t;

endpackage

// File: rtl/id_decoder.sv
// Combinational instruction decode: control bundle, imm select, illegal flag.
module id_decoder
  import id_pkg::*;
(
  input  logic [31:0] i_instr,
  output ctrl_t       o_ctrl,
  output logic [1:0]  o_imm_src,
  output logic        o_illegal
);

  logic [1:0] w_op;
  logic       w_i;
  logic       w_l;

  assign w_op = i_instr[27:26];
  assign w_i  = i_instr[25];
  assign w_l  = i_instr[20];

  always_comb begin
    o_ctrl    = '0;
    o_imm_src = IMM_U12;
    o_illegal = 1'b0;
    unique case (w_op)
      OP_DP: begin
        o_ctrl.reg_write = 1'b1;
        o_ctrl.alu_src   = w_i;
        o_ctrl.alu_op    = i_instr[23:21];
        o_ctrl.rd        = i_instr[15:12];
        o_imm_src        = w_i ? IMM_U8 : IMM_U12;
      end
      OP_MEM: begin
        o_ctrl.alu_src   = 1'b1;
        o_ctrl.alu_op    = ALU_ADD;
        o_ctrl.mem_read  = w_l;
        o_ctrl.reg_write = w_l;
        o_ctrl.mem_write = ~w_l;
        o_ctrl.rd        = i_instr[15:12];
      end
      OP_BR: begin
        o_ctrl.branch = 1'b1;
        o_ctrl.rd     = i_instr[15:12];
        o_imm_src     = IMM_S12;
      end
      default: o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/id_stage_ctrl.sv
// Decode-stage control: load-use hazard, bubble FSM, ID/EX register, stall counter.
module id_stage_ctrl
  import id_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  input  logic [31:0] instr,
  input  logic        ex_ready,
  input  logic        flush,
  output logic [1:0]  imm_src,
  output logic        id_ready,
  output logic        idex_valid,
  output logic        idex_reg_write,
  output logic        idex_mem_read,
  output logic        idex_mem_write,
  output logic        idex_alu_src,
  output logic        idex_branch,
  output logic [2:0]  idex_alu_op,
  output logic [3:0]  idex_rd,
  output logic        illegal,
  output logic [15:0] stall_cnt
);

  ctrl_t      w_ctrl;
  logic       w_dec_illegal;
  logic [3:0] w_rn;
  logic [3:0] w_rm;
  logic       w_load_use;

  state_e     r_state, w_state_nxt;
  ctrl_t      r_idex, w_idex_nxt;
  logic       r_idex_vld, w_vld_nxt;
  logic       w_idex_ld;
  logic       w_id_ready;
  logic       w_stall_inc;
  logic [15:0] r_stall_cnt;

  id_decoder u_dec (
    .i_instr   (instr),
    .o_ctrl    (w_ctrl),
    .o_imm_src (imm_src),
    .o_illegal (w_dec_illegal)
  );

  assign w_rn = instr[19:16];
  assign w_rm = instr[3:0];

  // Rm only matters when the operand comes from the register file.
  assign w_load_use = r_idex_vld & r_idex.mem_read & instr_valid &
                      ((r_idex.rd == w_rn) | (~w_ctrl.alu_src & (r_idex.rd == w_rm)));

  always_comb begin
    w_state_nxt = r_state;
    w_id_ready  = 1'b1;
    w_idex_ld   = 1'b0;
    w_idex_nxt  = '0;
    w_vld_nxt   = 1'b0;
    w_stall_inc = 1'b0;
    if (flush) begin
      w_idex_ld   = 1'b1;
      w_state_nxt = ST_RUN;
    end else if (!ex_ready) begin
      w_id_ready = 1'b0;
    end else if (r_state == ST_RUN && w_load_use) begin
      w_id_ready  = 1'b0;
      w_idex_ld   = 1'b1;
      w_stall_inc = 1'b1;
      w_state_nxt = ST_BUBBLE;
    end else begin
      w_idex_ld   = 1'b1;
      w_state_nxt = ST_RUN;
      if (instr_valid && !w_dec_illegal) begin
        w_idex_nxt = w_ctrl;
        w_vld_nxt  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_RUN;
      r_idex      <= '0;
      r_idex_vld  <= 1'b0;
      r_stall_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_idex_ld) begin
        r_idex     <= w_idex_nxt;
        r_idex_vld <= w_vld_nxt;
      end
      if (w_stall_inc && r_stall_cnt != STALL_MAX)
        r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  // Combinational handshakes are masked so reset drives every output low at once.
  assign id_ready       = rst_n & w_id_ready;
  assign illegal        = rst_n & w_id_ready & instr_valid & w_dec_illegal;
  assign idex_valid     = r_idex_vld;
  assign idex_reg_write = r_idex.reg_write;
  assign idex_mem_read  = r_idex.mem_read;
  assign idex_mem_write = r_idex.mem_write;
  assign idex_alu_src   = r_idex.alu_src;
  assign idex_branch    = r_idex.branch;
  assign idex_alu_op    = r_idex.alu_op;
  assign idex_rd        = r_idex.rd;
  assign stall_cnt      = r_stall_cnt;

endmodule

// File: tb/tb_id_stage_ctrl.sv
// Directed bench for id_stage_ctrl with hand-computed expectations.
module tb_id_stage_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, instr_valid, ex_ready, flush;
  logic [31:0] instr;
  logic [1:0]  imm_src;
  logic        id_ready, idex_valid, idex_reg_write, idex_mem_read, idex_mem_write;
  logic        idex_alu_src, idex_branch, illegal;
  logic [2:0]  idex_alu_op;
  logic [3:0]  idex_rd;
  logic [15:0] stall_cnt;

  int n_chk = 0;
  int n_err = 0;
  logic [15:0] exp_stall;

  always #5 clk = ~clk;

  id_stage_ctrl dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr(instr),
    .ex_ready(ex_ready), .flush(flush), .imm_src(imm_src), .id_ready(id_ready),
    .idex_valid(idex_valid), .idex_reg_write(idex_reg_write), .idex_mem_read(idex_mem_read),
    .idex_mem_write(idex_mem_write), .idex_alu_src(idex_alu_src), .idex_branch(idex_branch),
    .idex_alu_op(idex_alu_op), .idex_rd(idex_rd), .illegal(illegal), .stall_cnt(stall_cnt)
  );

  function automatic logic [31:0] mk(input logic [1:0] op, input logic i, input logic l,
                                     input logic [2:0] alu, input logic [3:0] rn,
                                     input logic [3:0] rd, input logic [3:0] rm);
    return {4'h0, op, i, 1'b0, alu, l, rn, rd, 8'h00, rm};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #3;
    n_chk++; if (idex_valid !== 1'b0) begin n_err++; $display("FAIL rst0_valid: got %0h want 0", idex_valid); end
    n_chk++; if (stall_cnt !== 16'h0) begin n_err++; $display("FAIL rst0_stall: got %0h want 0", stall_cnt); end
    n_chk++; if (id_ready !== 1'b0) begin n_err++; $display("FAIL rst0_id_ready: got %0h want 0", id_ready); end
    tick();
    rst_n = 1'b1;
    instr = mk(2'b00, 1'b1, 1'b0, 3'b011, 4'd1, 4'd9, 4'd2);
    instr_valid = 1'b1;
    tick();
    n_chk++; if (idex_valid !== 1'b1) begin n_err++; $display("FAIL pre_rst_valid: got %0h want 1", idex_valid); end
    #2 rst_n = 1'b0;
    #1;
    n_chk++; if ({idex_valid, idex_reg_write, idex_alu_src, idex_alu_op, idex_rd} !== 10'h0)
      begin n_err++; $display("FAIL async_rst_idex: got %0h want 0", {idex_valid, idex_reg_write, idex_alu_src, idex_alu_op, idex_rd}); end
    n_chk++; if ({id_ready, illegal} !== 2'b00) begin n_err++; $display("FAIL async_rst_hs: got %0h want 0", {id_ready, illegal}); end
    instr_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    exp_stall = 16'h0;
  endtask

  task automatic test_decode();
    instr = mk(2'b00, 1'b1, 1'b0, 3'b100, 4'd1, 4'd5, 4'd2); instr_valid = 1'b1;
    #1;
    n_chk++; if (imm_src !== 2'b01) begin n_err++; $display("FAIL dp_imm_imm: got %0h want 1", imm_src); end
    n_chk++; if (id_ready !== 1'b1) begin n_err++; $display("FAIL dp_id_ready: got %0h want 1", id_ready); end
    tick();
    n_chk++; if ({idex_valid, idex_alu_src, idex_alu_op, idex_reg_write, idex_mem_read, idex_rd} !== {1'b1, 1'b1, 3'b100, 1'b1, 1'b0, 4'd5})
      begin n_err++; $display("FAIL dp_imm_idex: got %0h want %0h", {idex_valid, idex_alu_src, idex_alu_op, idex_reg_write, idex_mem_read, idex_rd}, {1'b1, 1'b1, 3'b100, 1'b1, 1'b0, 4'd5}); end
    instr = mk(2'b00, 1'b0, 1'b0, 3'b010, 4'd1, 4'd6, 4'd2);
    #1;
    n_chk++; if (imm_src !== 2'b00) begin n_err++; $display("FAIL dp_reg_imm: got %0h want 0", imm_src); end
    tick();
    n_chk++; if ({idex_alu_src, idex_alu_op, idex_reg_write} !== {1'b0, 3'b010, 1'b1})
      begin n_err++; $display("FAIL dp_reg_idex: got %0h want %0h", {idex_alu_src, idex_alu_op, idex_reg_write}, {1'b0, 3'b010, 1'b1}); end
    instr = mk(2'b01, 1'b0, 1'b1, 3'b111, 4'd1, 4'd8, 4'd0);
    #1;
    n_chk++; if (imm_src !== 2'b00) begin n_err++; $display("FAIL ld_imm: got %0h want 0", imm_src); end
    tick();
    n_chk++; if ({idex_mem_read, idex_mem_write, idex_reg_write, idex_alu_src, idex_alu_op} !== {1'b1, 1'b0, 1'b1, 1'b1, 3'b000})
      begin n_err++; $display("FAIL ld_idex: got %0h want %0h", {idex_mem_read, idex_mem_write, idex_reg_write, idex_alu_src, idex_alu_op}, {1'b1, 1'b0, 1'b1, 1'b1, 3'b000}); end
    instr = mk(2'b01, 1'b0, 1'b0, 3'b000, 4'd2, 4'd9, 4'd8);
    tick();
    n_chk++; if ({idex_valid, idex_mem_read, idex_mem_write, idex_reg_write} !== 4'b1010)
      begin n_err++; $display("FAIL st_idex: got %0h want a", {idex_valid, idex_mem_read, idex_mem_write, idex_reg_write}); end
    instr = mk(2'b10, 1'b0, 1'b0, 3'b000, 4'd0, 4'd0, 4'd0);
    #1;
    n_chk++; if (imm_src !== 2'b10) begin n_err++; $display("FAIL br_imm: got %0h want 2", imm_src); end
    tick();
    n_chk++; if ({idex_valid, idex_branch, idex_reg_write} !== 3'b110)
      begin n_err++; $display("FAIL br_idex: got %0h want 6", {idex_valid, idex_branch, idex_reg_write}); end
    instr_valid = 1'b0;
    tick();
    n_chk++; if ({idex_valid, idex_branch} !== 2'b00) begin n_err++; $display("FAIL no_instr_bubble: got %0h want 0", {idex_valid, idex_branch}); end
  endtask

  task automatic test_load_use();
    instr = mk(2'b01, 1'b0, 1'b1, 3'b000, 4'd1, 4'd3, 4'd0); instr_valid = 1'b1;
    tick();
    instr = mk(2'b00, 1'b1, 1'b0, 3'b001, 4'd3, 4'd7, 4'd0);
    #1;
    n_chk++; if (id_ready !== 1'b0) begin n_err++; $display("FAIL lu_rn_stall: got %0h want 0", id_ready); end
    tick(); exp_stall = exp_stall + 16'd1;
    n_chk++; if ({idex_valid, idex_reg_write, idex_mem_read} !== 3'b000) begin n_err++; $display("FAIL lu_bubble: got %0h want 0", {idex_valid, idex_reg_write, idex_mem_read}); end
    n_chk++; if (stall_cnt !== exp_stall) begin n_err++; $display("FAIL lu_cnt: got %0h want %0h", stall_cnt, exp_stall); end
    n_chk++; if (id_ready !== 1'b1) begin n_err++; $display("FAIL lu_reissue_ready: got %0h want 1", id_ready); end
    tick();
    n_chk++; if ({idex_valid, idex_reg_write, idex_rd} !== {1'b1, 1'b1, 4'd7}) begin n_err++; $display("FAIL lu_issue: got %0h want %0h", {idex_valid, idex_reg_write, idex_rd}, {1'b1, 1'b1, 4'd7}); end
    instr = mk(2'b01, 1'b0, 1'b1, 3'b000, 4'd1, 4'd4, 4'd0);
    tick();
    instr = mk(2'b00, 1'b0, 1'b0, 3'b000, 4'd1, 4'd11, 4'd4);
    #1;
    n_chk++; if (id_ready !== 1'b0) begin n_err++; $display("FAIL lu_rm_stall: got %0h want 0", id_ready); end
    tick(); exp_stall = exp_stall + 16'd1;
    tick();
    n_chk++; if ({idex_valid, idex_rd} !== {1'b1, 4'd11}) begin n_err++; $display("FAIL lu_rm_issue: got %0h want %0h", {idex_valid, idex_rd}, {1'b1, 4'd11}); end
    instr = mk(2'b01, 1'b0, 1'b1, 3'b000, 4'd1, 4'd4, 4'd0);
    tick();
    instr = mk(2'b00, 1'b1, 1'b0, 3'b000, 4'd1, 4'd12, 4'd4);
    #1;
    n_chk++; if (id_ready !== 1'b1) begin n_err++; $display("FAIL lu_rm_imm_nostall: got %0h want 1", id_ready); end
    tick();
    n_chk++; if (stall_cnt !== exp_stall) begin n_err++; $display("FAIL lu_cnt2: got %0h want %0h", stall_cnt, exp_stall); end
    instr_valid = 1'b0;
    tick();
  endtask

  task automatic test_ex_stall();
    instr = mk(2'b00, 1'b1, 1'b0, 3'b001, 4'd1, 4'd9, 4'd0); instr_valid = 1'b1;
    tick();
    ex_ready = 1'b0;
    instr = mk(2'b00, 1'b1, 1'b0, 3'b010, 4'd1, 4'd10, 4'd0);
    for (int c = 0; c < 3; c++) begin
      #1;
      n_chk++; if (id_ready !== 1'b0) begin n_err++; $display("FAIL exst_ready[%0d]: got %0h want 0", c, id_ready); end
      tick();
      n_chk++; if ({idex_valid, idex_alu_op, idex_rd} !== {1'b1, 3'b001, 4'd9}) begin n_err++; $display("FAIL exst_hold[%0d]: got %0h want %0h", c, {idex_valid, idex_alu_op, idex_rd}, {1'b1, 3'b001, 4'd9}); end
      n_chk++; if (stall_cnt !== exp_stall) begin n_err++; $display("FAIL exst_cnt[%0d]: got %0h want %0h", c, stall_cnt, exp_stall); end
    end
    ex_ready = 1'b1;
    tick();
    n_chk++; if (idex_rd !== 4'd10) begin n_err++; $display("FAIL exst_release: got %0h want a", idex_rd); end
  endtask

  task automatic test_flush();
    instr = mk(2'b01, 1'b0, 1'b1, 3'b000, 4'd1, 4'd2, 4'd0); instr_valid = 1'b1;
    tick();
    instr = mk(2'b00, 1'b1, 1'b0, 3'b000, 4'd2, 4'd12, 4'd0);
    tick(); exp_stall = exp_stall + 16'd1;
    flush = 1'b1;
    #1;
    n_chk++; if (id_ready !== 1'b1) begin n_err++; $display("FAIL fl_ready: got %0h want 1", id_ready); end
    tick();
    flush = 1'b0;
    n_chk++; if ({idex_valid, idex_reg_write, idex_rd} !== 6'h0) begin n_err++; $display("FAIL fl_idex: got %0h want 0", {idex_valid, idex_reg_write, idex_rd}); end
    n_chk++; if (stall_cnt !== exp_stall) begin n_err++; $display("FAIL fl_cnt: got %0h want %0h", stall_cnt, exp_stall); end
    instr = mk(2'b00, 1'b1, 1'b0, 3'b000, 4'd1, 4'd13, 4'd0);
    tick();
    n_chk++; if ({idex_valid, idex_rd} !== {1'b1, 4'd13}) begin n_err++; $display("FAIL fl_resume: got %0h want %0h", {idex_valid, idex_rd}, {1'b1, 4'd13}); end
    ex_ready = 1'b0; flush = 1'b1;
    tick();
    n_chk++; if (idex_valid !== 1'b0) begin n_err++; $display("FAIL fl_over_exready: got %0h want 0", idex_valid); end
    ex_ready = 1'b1; flush = 1'b0; instr_valid = 1'b0;
    tick();
  endtask

  task automatic test_illegal();
    instr = mk(2'b11, 1'b1, 1'b0, 3'b101, 4'd1, 4'd5, 4'd0); instr_valid = 1'b1;
    #1;
    n_chk++; if ({illegal, imm_src} !== 3'b100) begin n_err++; $display("FAIL ill_pulse: got %0h want 4", {illegal, imm_src}); end
    tick();
    instr_valid = 1'b0;
    #1;
    n_chk++; if (illegal !== 1'b0) begin n_err++; $display("FAIL ill_one_cycle: got %0h want 0", illegal); end
    n_chk++; if ({idex_valid, idex_reg_write} !== 2'b00) begin n_err++; $display("FAIL ill_idex: got %0h want 0", {idex_valid, idex_reg_write}); end
    instr_valid = 1'b1; ex_ready = 1'b0;
    #1;
    n_chk++; if (illegal !== 1'b0) begin n_err++; $display("FAIL ill_not_consumed: got %0h want 0", illegal); end
    ex_ready = 1'b1; instr_valid = 1'b0;
    tick();
  endtask

  task automatic test_saturation();
    force dut.r_stall_cnt = 16'hFFFE;
    #1;
    release dut.r_stall_cnt;
    for (int k = 0; k < 2; k++) begin
      instr = mk(2'b01, 1'b0, 1'b1, 3'b000, 4'd1, 4'd3, 4'd0); instr_valid = 1'b1;
      tick();
      instr = mk(2'b00, 1'b1, 1'b0, 3'b000, 4'd3, 4'd7, 4'd0);
      tick();
      n_chk++; if (stall_cnt !== 16'hFFFF) begin n_err++; $display("FAIL sat[%0d]: got %0h want ffff", k, stall_cnt); end
      tick();
    end
    instr_valid = 1'b0;
    tick();
    n_chk++; if (stall_cnt !== 16'hFFFF) begin n_err++; $display("FAIL sat_idle: got %0h want ffff", stall_cnt); end
  endtask

  task automatic test_reset_mid_stall();
    instr = mk(2'b01, 1'b0, 1'b1, 3'b000, 4'd1, 4'd6, 4'd0); instr_valid = 1'b1;
    tick();
    instr = mk(2'b00, 1'b1, 1'b0, 3'b000, 4'd6, 4'd7, 4'd0);
    tick();
    rst_n = 1'b0;
    #1;
    n_chk++; if ({stall_cnt, idex_valid, id_ready} !== 18'h0) begin n_err++; $display("FAIL mid_rst: got %0h want 0", {stall_cnt, idex_valid, id_ready}); end
    tick();
    rst_n = 1'b1; exp_stall = 16'h0;
    instr = mk(2'b00, 1'b1, 1'b0, 3'b110, 4'd1, 4'd14, 4'd0);
    #1;
    n_chk++; if (id_ready !== 1'b1) begin n_err++; $display("FAIL post_rst_ready: got %0h want 1", id_ready); end
    tick();
    n_chk++; if ({idex_valid, idex_alu_op, idex_rd} !== {1'b1, 3'b110, 4'd14}) begin n_err++; $display("FAIL post_rst_issue: got %0h want %0h", {idex_valid, idex_alu_op, idex_rd}, {1'b1, 3'b110, 4'd14}); end
    instr = mk(2'b01, 1'b0, 1'b1, 3'b000, 4'd1, 4'd6, 4'd0);
    tick();
    instr = mk(2'b00, 1'b1, 1'b0, 3'b000, 4'd6, 4'd7, 4'd0);
    #1;
    n_chk++; if (id_ready !== 1'b0) begin n_err++; $display("FAIL post_rst_hazard: got %0h want 0", id_ready); end
    tick(); exp_stall = exp_stall + 16'd1;
    n_chk++; if (stall_cnt !== exp_stall) begin n_err++; $display("FAIL post_rst_cnt: got %0h want %0h", stall_cnt, exp_stall); end
    instr_valid = 1'b0;
    tick();
  endtask

  initial begin
    rst_n = 1'b0; instr_valid = 1'b0; instr = '0; ex_ready = 1'b1; flush = 1'b0;
    exp_stall = 16'h0;
    test_reset();
    test_decode();
    test_load_use();
    test_ex_stall();
    test_flush();
    test_illegal();
    test_saturation();
    test_reset_mid_stall();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
